// File: rtl/data_mem_pkg.sv
// Shared types and encodings for the data-memory responder.
package data_mem_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WIDX_W = XLEN - 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic            write;
    logic [1:0]      size;
    logic            is_unsigned;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half/word lane steering: merges store data into the old word and
// extracts/extends load data from it.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] old_word,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] wr_word_c,
  output logic [XLEN-1:0] ld_data_c,
  output logic            misalign_c
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wr_word_c  = old_word;
    ld_data_c  = '0;
    misalign_c = 1'b0;
    ld_byte    = old_word[{addr_lo, 3'b000} +: 8];
    ld_half    = old_word[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        wr_word_c[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        ld_data_c = is_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        misalign_c = addr_lo[0];
        wr_word_c[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
        ld_data_c = is_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      SZ_WORD: begin
        misalign_c = |addr_lo;
        wr_word_c  = wdata;
        ld_data_c  = old_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU load/store port: one outstanding request,
// fixed access latency, word array with byte/half/word lanes.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_req_t         req_q;
  logic             req_ready_d, resp_valid_d, resp_err_d;
  logic [XLEN-1:0]  resp_rdata_d;
  logic             latch_en_c, mem_we_c, oob_c, misalign_c, bad_size_c, err_c;
  logic [XLEN-1:0]  old_word_c, wr_word_c, ld_data_c;
  logic [IDX_W-1:0] idx_c;

  logic [XLEN-1:0] mem [0:DEPTH-1];

  // Error classification always uses the latched request.
  assign idx_c      = req_q.addr[IDX_W+1:2];
  assign oob_c      = (req_q.addr[XLEN-1:2] >= WIDX_W'(DEPTH));
  assign bad_size_c = (req_q.size != SZ_BYTE) && (req_q.size != SZ_HALF) &&
                      (req_q.size != SZ_WORD);
  assign err_c      = bad_size_c || misalign_c || oob_c;
  assign old_word_c = oob_c ? '0 : mem[idx_c];

  mem_lane_align u_align (
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .addr_lo     (req_q.addr[1:0]),
    .old_word    (old_word_c),
    .wdata       (req_q.wdata),
    .wr_word_c   (wr_word_c),
    .ld_data_c   (ld_data_c),
    .misalign_c  (misalign_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready;
    resp_valid_d = resp_valid;
    resp_rdata_d = resp_rdata;
    resp_err_d   = resp_err;
    latch_en_c   = 1'b0;
    mem_we_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          latch_en_c  = 1'b1;
          cnt_d       = CNT_W'(LATENCY - 1);
          req_ready_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          mem_we_c     = req_q.write && !err_c;
          resp_valid_d = 1'b1;
          resp_err_d   = err_c;
          resp_rdata_d = (err_c || req_q.write) ? '0 : ld_data_c;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
      if (latch_en_c) begin
        req_q <= '{write: req_write, size: req_size, is_unsigned: req_unsigned,
                   addr: req_addr, wdata: req_wdata};
      end
    end
  end

  // Array contents survive reset; only the commit edge writes.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[idx_c] <= wr_word_c;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder with a byte-array reference model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_write, b_req_unsigned;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_resp_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] ref0 [0:4*DEPTH-1];
  logic [7:0] ref1 [0:4*DEPTH-1];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  // Reference model: byte-addressed little-endian memory, access rules by arithmetic.
  function automatic void mdl(input bit inst, input logic w, input logic [1:0] sz,
                              input logic u, input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er);
    int unsigned n;
    logic [31:0] v;
    n  = 1 << sz;
    er = (sz == 2'd3) || ((a % n) != 0) || ((a / 4) >= DEPTH);
    rd = 32'h0;
    if (er) return;
    if (w) begin
      for (int i = 0; i < int'(n); i++) begin
        if (inst) ref1[a + i] = wd[8*i +: 8];
        else      ref0[a + i] = wd[8*i +: 8];
      end
    end else begin
      v = 32'h0;
      for (int i = 0; i < int'(n); i++)
        v = v | (32'(inst ? ref1[a + i] : ref0[a + i]) << (8 * i));
      if (!u && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      rd = v;
    end
  endfunction

  task automatic do_txn(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int g;
    g = 0;
    while (req_ready !== 1'b1 && g < 40) begin @(posedge clk); #1; g++; end
    if (req_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL req_ready_timeout: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom(); req_wdata = $urandom();
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    rd = resp_rdata;
    er = resp_err;
  endtask

  task automatic finish_resp(input int delay);
    resp_ready = 1'b0;
    repeat (delay) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({req_ready, resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b vld=%b err=%b rdata=%h required 1 0 0 0",
               req_ready, resp_valid, resp_err, resp_rdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: rdy=%b vld=%b required 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_init();
    logic [31:0] rd, erd; logic er, ere; int lat;
    for (int i = 0; i < 4 * int'(DEPTH); i++) ref1[i] = 8'hxx;
    for (int w = 0; w < int'(DEPTH); w++) begin
      do_txn(1'b1, 2'b10, 1'b0, 32'(w * 4), 32'h0, rd, er, lat);
      mdl(1'b0, 1'b1, 2'b10, 1'b0, 32'(w * 4), 32'h0, erd, ere);
      finish_resp(0);
    end
  endtask

  task automatic test_word_store_load();
    logic [31:0] rd, erd; logic er, ere; int lat;
    do_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    mdl(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, erd, ere);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'h0} || lat != int'(LAT)) begin
      n_bad++;
      $display("FAIL word_store: err=%b rdata=%h lat=%0d required 0 0 %0d", er, rd, lat, LAT);
    end
    finish_resp(1);
    do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'hDEADBEEF} || lat != int'(LAT)) begin
      n_bad++;
      $display("FAIL word_load: err=%b rdata=%h lat=%0d required 0 deadbeef %0d", er, rd, lat, LAT);
    end
    finish_resp(0);
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd, erd; logic er, ere; int lat;
    logic [31:0] exp_v [3];
    logic [1:0]  szs [3];
    logic        uns [3];
    exp_v = '{32'hFFFFFF80, 32'h00000080, 32'h00008000};
    szs   = '{2'b00, 2'b00, 2'b10};
    uns   = '{1'b0, 1'b1, 1'b0};
    do_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    mdl(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, erd, ere);
    finish_resp(0);
    do_txn(1'b1, 2'b00, 1'b0, 32'h11, 32'hABCDEF80, rd, er, lat);
    mdl(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hABCDEF80, erd, ere);
    finish_resp(0);
    for (int i = 0; i < 3; i++) begin
      do_txn(1'b0, szs[i], uns[i], (szs[i] == 2'b10) ? 32'h10 : 32'h11, 32'h0, rd, er, lat);
      n_cmp++;
      if ({er, rd} !== {1'b0, exp_v[i]}) begin
        n_bad++;
        $display("FAIL byte_lane_load%0d: err=%b rdata=%h required 0 %h", i, er, rd, exp_v[i]);
      end
      finish_resp(0);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, ere; int lat;
    do_txn(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL half_misalign: err=%b rdata=%h required 1 0", er, rd);
    end
    finish_resp(0);
    do_txn(1'b1, 2'b10, 1'b0, 32'h402, 32'hCAFEF00D, rd, er, lat);
    mdl(1'b0, 1'b1, 2'b10, 1'b0, 32'h402, 32'hCAFEF00D, erd, ere);
    n_cmp++;
    if ({er, rd} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL oob_store: err=%b rdata=%h required 1 0", er, rd);
    end
    finish_resp(0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lat);
    mdl(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, erd, ere);
    n_cmp++;
    if ({er, rd} !== {ere, erd}) begin
      n_bad++;
      $display("FAIL oob_readback: err=%b rdata=%h required %b %h", er, rd, ere, erd);
    end
    finish_resp(0);
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, erd; logic er, ere; int lat;
    mdl(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, erd, ere);
    do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = i[0]; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h40; req_wdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      n_cmp++;
      if ({resp_valid, req_ready, resp_err, resp_rdata} !== {1'b1, 1'b0, ere, erd}) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: vld=%b rdy=%b err=%b rdata=%h required 1 0 %b %h",
                 i, resp_valid, req_ready, resp_err, resp_rdata, ere, erd);
      end
    end
    req_valid = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL handshake_no_accept: rdy=%b vld=%b required 1 0", req_ready, resp_valid);
    end
    do_txn(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
    mdl(1'b0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, erd, ere);
    n_cmp++;
    if ({er, rd} !== {ere, erd}) begin
      n_bad++;
      $display("FAIL ignored_store_readback: err=%b rdata=%h required %b %h", er, rd, ere, erd);
    end
    finish_resp(0);
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd, erd; logic er, ere; int lat;
    do_txn(1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5A5A5, rd, er, lat);
    mdl(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5A5A5, erd, ere);
    finish_resp(0);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL async_reset_outputs: rdy=%b vld=%b err=%b rdata=%h required 1 0 0 0",
               req_ready, resp_valid, resp_err, resp_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'hA5A5A5A5}) begin
      n_bad++;
      $display("FAIL dropped_store: err=%b rdata=%h required 0 a5a5a5a5", er, rd);
    end
    finish_resp(0);
  endtask

  task automatic test_illegal_size();
    logic [31:0] rd, erd; logic er, ere; int lat;
    do_txn(1'b1, 2'b11, 1'b0, 32'h30, 32'hFFFFFFFF, rd, er, lat);
    mdl(1'b0, 1'b1, 2'b11, 1'b0, 32'h30, 32'hFFFFFFFF, erd, ere);
    n_cmp++;
    if ({er, rd} !== {1'b1, 32'h0} || lat != int'(LAT)) begin
      n_bad++;
      $display("FAIL size11_store: err=%b rdata=%h lat=%0d required 1 0 %0d", er, rd, lat, LAT);
    end
    finish_resp(0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er, lat);
    mdl(1'b0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, erd, ere);
    n_cmp++;
    if ({er, rd} !== {ere, erd}) begin
      n_bad++;
      $display("FAIL size11_readback: err=%b rdata=%h required %b %h", er, rd, ere, erd);
    end
    finish_resp(0);
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, wd; logic er, ere, w, u; logic [1:0] sz; int lat;
    for (int i = 0; i < 80; i++) begin
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      wd = $urandom();
      a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(4 * DEPTH, 4 * DEPTH + 64))
                                       : 32'($urandom_range(0, 4 * DEPTH - 1));
      do_txn(w, sz, u, a, wd, rd, er, lat);
      mdl(1'b0, w, sz, u, a, wd, erd, ere);
      n_cmp++;
      if ({er, rd} !== {ere, erd} || lat != int'(LAT)) begin
        n_bad++;
        $display("FAIL random%0d w=%b sz=%0d u=%b a=%h: err=%b rdata=%h lat=%0d required %b %h %0d",
                 i, w, sz, u, a, er, rd, lat, ere, erd, LAT);
      end
      finish_resp(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] erd, a, wd; logic ere, u; logic [1:0] sz; int g, prev, t_acc;
    logic [31:0] base;
    prev = -1;
    base = 32'h0;
    b_resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (!i[0]) begin
        base = 32'($urandom_range(0, DEPTH - 1) * 4);
        sz = 2'b10; u = 1'b0; a = base; wd = $urandom();
        b_req_write = 1'b1;
      end else begin
        sz = 2'($urandom_range(0, 2)); u = 1'($urandom_range(0, 1)); wd = $urandom();
        a  = base + ((sz == 2'b00) ? 32'($urandom_range(0, 3)) :
                     (sz == 2'b01) ? 32'($urandom_range(0, 1) * 2) : 32'h0);
        b_req_write = 1'b0;
      end
      mdl(1'b1, b_req_write, sz, u, a, wd, erd, ere);
      b_req_valid = 1'b1; b_req_size = sz; b_req_unsigned = u;
      b_req_addr = a; b_req_wdata = wd;
      g = 0;
      while (b_req_ready !== 1'b1 && g < 20) begin @(posedge clk); #1; g++; end
      if (b_req_ready !== 1'b1) begin
        n_cmp++; n_bad++;
        $display("FAIL b2b_ready_timeout%0d: req_ready=%b required 1", i, b_req_ready);
      end
      @(posedge clk); #1;
      t_acc = cyc;
      if (prev >= 0) begin
        n_cmp++;
        if (t_acc - prev != 3) begin
          n_bad++;
          $display("FAIL b2b_spacing%0d: got %0d cycles required 3", i, t_acc - prev);
        end
      end
      prev = t_acc;
      @(posedge clk); #1;
      n_cmp++;
      if ({b_resp_valid, b_resp_err, b_resp_rdata} !== {1'b1, ere, erd}) begin
        n_bad++;
        $display("FAIL b2b_resp%0d a=%h sz=%0d: vld=%b err=%b rdata=%h required 1 %b %h",
                 i, a, sz, b_resp_valid, b_resp_err, b_resp_rdata, ere, erd);
      end
    end
    b_req_valid = 1'b0;
    @(posedge clk); #1;
    b_resp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_size = 2'b00; b_req_unsigned = 1'b0;
    b_req_addr = 32'h0; b_req_wdata = 32'h0; b_resp_ready = 1'b0;
    test_reset();
    test_init();
    test_word_store_load();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_reset_mid_wait();
    test_illegal_size();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
